// File: rtl/m_bin2bcd_disp_pkg.sv
// Shared constants, types and the per-digit add-3 helper for the
// binary-to-BCD display converter.
package m_7seg_pkg;

  localparam int DISP_W     = 32;
  localparam int NUM_DIGITS = 8;
  localparam int DEC_MAX    = 99_999_999;
  localparam logic [DISP_W-1:0] OVF_PATTERN = 32'hFFFF_FFFF;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Pre-shift correction: digits 5..9 become 8..12 so the shift carries out.
  function automatic bcd_digit_t dabble_adj(input bcd_digit_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/m_bin2bcd_disp_if.sv
// Request/display bundle between a producer and the converter.
// Handshake: a transfer happens on a rising clk edge where in_valid and in_ready are both high; in_valid while in_ready is low is dropped, never queued.
interface m_bin2bcd_disp_if
  import m_7seg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_hex;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] sev_seg_disp;
  logic                  disp_upd;
  logic                  ovf;
  logic                  busy;
  state_t                dbg_state;

  modport master (
    output in_valid, in_data, in_hex,
    input  in_ready, sev_seg_disp, disp_upd, ovf, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_data, in_hex,
    output in_ready, sev_seg_disp, disp_upd, ovf, busy, dbg_state
  );

endinterface

// File: rtl/m_bin2bcd_disp_dabble_step.sv
// One double-dabble iteration: add-3 on every BCD digit, then shift
// {bcd, bin} left by one bit. The bit leaving the top digit is dropped.
module m_dabble_step
  import m_7seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 32
) (
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic [BIN_W-1:0]        bin_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = dabble_adj(bcd_i[4*i +: 4]);
    end
    {bcd_o, bin_o} = {adj[BCD_W-2:0], bin_i, 1'b0};
  end

endmodule

// File: rtl/m_bin2bcd_disp.sv
// Binary-to-packed-BCD converter for the seven-segment display word,
// with raw hex passthrough and an all-F overflow pattern.
module m_bin2bcd_disp #(
  parameter int DATA_WIDTH = m_7seg_pkg::DISP_W,
  parameter int NUM_DIGITS = m_7seg_pkg::NUM_DIGITS,
  parameter logic [DATA_WIDTH-1:0] DEC_MAX = DATA_WIDTH'(m_7seg_pkg::DEC_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  m_bin2bcd_disp_if.slave  bus
);

  import m_7seg_pkg::*;

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] disp_q, disp_d;
  logic                  upd_q, upd_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] bcd_nx;
  logic [DATA_WIDTH-1:0] bin_nx;
  logic                  accept;
  logic                  too_big;
  logic                  last_shift;

  m_dabble_step #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (DATA_WIDTH)
  ) u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_o (bcd_nx),
    .bin_o (bin_nx)
  );

  assign accept     = bus.in_valid && (state_q == ST_IDLE);
  assign too_big    = bus.in_data > DEC_MAX;
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !bus.in_hex && !too_big) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.dbg_state = state_q;
  end

  // Datapath next values; the display only changes on an immediate
  // transfer or on the final shift, never with a partial result.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    upd_d  = 1'b0;
    if (accept) begin
      if (bus.in_hex) begin
        disp_d = bus.in_data;
        ovf_d  = 1'b0;
        upd_d  = 1'b1;
      end else if (too_big) begin
        disp_d = DATA_WIDTH'(OVF_PATTERN);
        ovf_d  = 1'b1;
        upd_d  = 1'b1;
      end else begin
        bin_d = bus.in_data;
        bcd_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end else if (state_q == ST_SHIFT) begin
      bin_d = bin_nx;
      bcd_d = bcd_nx;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_shift) begin
        disp_d = bcd_nx;
        ovf_d  = 1'b0;
        upd_d  = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
      upd_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      upd_q  <= upd_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.sev_seg_disp = disp_q;
  assign bus.disp_upd     = upd_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_m_bin2bcd_disp.sv
// Self-checking bench for m_bin2bcd_disp: directed scenarios plus a
// scoreboard that pairs every disp_upd pulse with an expected display word.
module tb_m_bin2bcd_disp;
  import m_7seg_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   upd_cnt;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  m_bin2bcd_disp_if #(.DATA_WIDTH(W)) bus ();

  m_bin2bcd_disp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: decimal digits by repeated division.
  function automatic logic [W-1:0] to_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_disp(input logic [W-1:0] d, input logic h);
    if (h) return d;
    if (d > 32'd99_999_999) return 32'hFFFF_FFFF;
    return to_bcd(d);
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] d, input logic h);
    return !h && (d > 32'd99_999_999);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.disp_upd === 1'b1) begin
      logic [W-1:0] e;
      logic         eo;
      upd_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_upd: disp=%h with no expected entry", bus.sev_seg_disp);
      end else begin
        e  = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (bus.sev_seg_disp !== e) begin
          errors++;
          $display("FAIL sb_disp: got %h expected %h", bus.sev_seg_disp, e);
        end
        checks++;
        if (bus.ovf !== eo) begin
          errors++;
          $display("FAIL sb_ovf: got %b expected %b", bus.ovf, eo);
        end
      end
    end
  end

  // Driver tasks (called at #1 after a rising edge)
  task automatic send_req(input logic [W-1:0] d, input logic h, input bit push);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_send: got %b expected 1", bus.in_ready);
    end
    if (push) begin
      exp_q.push_back(model_disp(d, h));
      exp_ovf_q.push_back(model_ovf(d, h));
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_hex   = h;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_hex   = 1'b0;
    idle_cycles(2);
    checks++; if (bus.sev_seg_disp !== 32'h0) begin errors++; $display("FAIL rst_disp: got %h expected 00000000", bus.sev_seg_disp); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.disp_upd !== 1'b0) begin errors++; $display("FAIL rst_upd: got %b expected 0", bus.disp_upd); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", bus.dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decimal(input logic [W-1:0] val);
    int u0;
    int cyc;
    logic [W-1:0] e;
    u0  = upd_cnt;
    e   = to_bcd(val);
    send_req(val, 1'b0, 1'b1);
    cyc = 1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL dec_busy_start: ready=%b expected 0", bus.in_ready); end
    while (bus.in_ready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b1) cyc++;
    end
    checks++; if (cyc != 32) begin errors++; $display("FAIL dec_latency: busy %0d cycles expected 32 (val %0d)", cyc, val); end
    checks++; if (bus.sev_seg_disp !== e) begin errors++; $display("FAIL dec_result: got %h expected %h", bus.sev_seg_disp, e); end
    checks++; if (bus.disp_upd !== 1'b1) begin errors++; $display("FAIL dec_upd: got %b expected 1", bus.disp_upd); end
    @(posedge clk); #1;
    checks++; if (bus.disp_upd !== 1'b0) begin errors++; $display("FAIL dec_upd_single: got %b expected 0", bus.disp_upd); end
    checks++; if (upd_cnt != u0 + 1) begin errors++; $display("FAIL dec_upd_count: got %0d expected %0d", upd_cnt - u0, 1); end
  endtask

  task automatic test_overflow();
    send_req(32'd100_000_000, 1'b0, 1'b1);
    checks++; if (bus.sev_seg_disp !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_disp: got %h expected ffffffff", bus.sev_seg_disp); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.ovf); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    test_decimal(32'd7);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_hex();
    send_req(32'hDEAD_BEEF, 1'b1, 1'b1);
    checks++; if (bus.sev_seg_disp !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hex_disp: got %h expected deadbeef", bus.sev_seg_disp); end
    checks++; if (bus.disp_upd !== 1'b1) begin errors++; $display("FAIL hex_upd: got %b expected 1", bus.disp_upd); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int u0;
    u0 = upd_cnt;
    exp_q.push_back(32'h1); exp_ovf_q.push_back(1'b0);
    exp_q.push_back(32'h2); exp_ovf_q.push_back(1'b0);
    bus.in_valid = 1'b1; bus.in_hex = 1'b1; bus.in_data = 32'h1;
    @(posedge clk); #1;
    bus.in_data = 32'h2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.sev_seg_disp !== 32'h2) begin errors++; $display("FAIL b2b_disp: got %h expected 00000002", bus.sev_seg_disp); end
    @(posedge clk); #1;
    checks++; if (upd_cnt != u0 + 2) begin errors++; $display("FAIL b2b_upd_count: got %0d expected 2", upd_cnt - u0); end
  endtask

  task automatic test_busy_ignore();
    int u0;
    int cyc;
    u0 = upd_cnt;
    send_req(32'd42, 1'b0, 1'b1);
    idle_cycles(4);
    bus.in_valid = 1'b1; bus.in_hex = 1'b1; bus.in_data = 32'h55;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (bus.sev_seg_disp !== 32'h42) begin errors++; $display("FAIL ignore_disp: got %h expected 00000042", bus.sev_seg_disp); end
    idle_cycles(3);
    checks++; if (upd_cnt != u0 + 1) begin errors++; $display("FAIL ignore_upd_count: got %0d expected 1", upd_cnt - u0); end
  endtask

  task automatic test_reset_mid();
    int u0;
    u0 = upd_cnt;
    send_req(32'd12_345_678, 1'b0, 1'b0);
    idle_cycles(9);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.sev_seg_disp !== 32'h0) begin errors++; $display("FAIL midrst_disp: got %h expected 00000000", bus.sev_seg_disp); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.disp_upd !== 1'b0) begin errors++; $display("FAIL midrst_upd: got %b expected 0", bus.disp_upd); end
    idle_cycles(2);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(35);
    checks++; if (upd_cnt != u0) begin errors++; $display("FAIL midrst_no_upd: got %0d pulses expected 0", upd_cnt - u0); end
    test_decimal(32'd12_345_678);
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = W'($urandom_range(99_999_999, 0));
      test_decimal(v);
    end
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      send_req(v, 1'b1, 1'b1);
      checks++; if (bus.sev_seg_disp !== v) begin errors++; $display("FAIL rand_hex: got %h expected %h", bus.sev_seg_disp, v); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    upd_cnt = 0;
    rst     = 1'b1;
    test_reset();
    test_decimal(32'd12_345_678);
    test_decimal(32'd0);
    test_decimal(32'd99_999_999);
    test_overflow();
    test_hex();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    idle_cycles(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
